// File: rtl/video_pkg.sv
// Shared definitions for the video scaling path: scale encodings, FSM states,
// pipeline latency and small arithmetic helpers.
package video_pkg;

    typedef enum logic [1:0] {
        SCALE_X1 = 2'd0,
        SCALE_X2 = 2'd1,
        SCALE_X4 = 2'd2
    } scale_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } state_t;

    localparam int LATENCY = 3;

    // Scale factor as a left-shift amount; the reserved encoding falls back to x1.
    function automatic logic [1:0] scale_shift(input logic [1:0] mode);
        case (mode)
            SCALE_X2: return 2'd1;
            SCALE_X4: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic [11:0] centre_offset(input logic [15:0] dst, input logic [15:0] span);
        logic [15:0] diff;
        diff = dst - span;
        return (span < dst) ? diff[12:1] : 12'd0;
    endfunction

    // c_left holds the ch_w-bit channel left-justified; its bits repeat MSB-first.
    function automatic logic [7:0] expand_ch(input logic [7:0] c_left, input int ch_w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[7-i] = c_left[7-(i%ch_w)];
        return r;
    endfunction

endpackage

// File: rtl/video_sync_delay.sv
// Delay line carrying vde/hsync/vsync and the in-window flag alongside the
// pixel pipeline so they stay aligned with the returned BRAM data.
module video_sync_delay #(
    parameter int DEPTH = 2
) (
    input  logic i_clk_pixel,
    input  logic i_rstn,
    input  logic i_vde,
    input  logic i_hsync,
    input  logic i_vsync,
    input  logic i_win,
    output logic o_vde,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_win
);

    logic [3:0] pipe [DEPTH];

    // NOTE: the delay array is reset, unlike a data memory, because its taps drive visible outputs.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {i_vde, i_hsync, i_vsync, i_win};
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {o_vde, o_hsync, o_vsync, o_win} = pipe[DEPTH-1];

endmodule

// File: rtl/video_frame_scaler.sv
// Nearest-neighbour x1/x2/x4 upscaler between the timing generator and the
// frame-buffer read port, with centring, cropping and a border colour.
module video_frame_scaler
    import video_pkg::*;
#(
    parameter int SRC_H  = 512,
    parameter int SRC_V  = 384,
    parameter int DST_H  = 1024,
    parameter int DST_V  = 768,
    parameter int CH_W   = 4,
    parameter int ADDR_W = 18
) (
    input  logic                i_clk_pixel,
    input  logic                i_rstn,
    input  logic [1:0]          i_scale_mode,
    input  logic [23:0]         i_border_rgb,
    input  logic                i_vde,
    input  logic                i_hsync,
    input  logic                i_vsync,
    output logic                o_rd_en,
    output logic [ADDR_W-1:0]   o_rd_addr,
    input  logic [3*CH_W-1:0]   i_rd_data,
    output logic [23:0]         o_video_data,
    output logic                o_video_vde,
    output logic                o_video_hsync,
    output logic                o_video_vsync
);

    localparam int PIX_W = 3 * CH_W;

    state_t            state;
    logic [1:0]        shift;
    logic [23:0]       border_rgb;
    logic [11:0]       off_x, off_y, cx, ly;
    logic [1:0]        hsub, vsub;
    logic [ADDR_W-1:0] src_col, row_base;
    logic              vde_q;

    logic [1:0]  mode_shift, sub_last;
    logic [15:0] end_x, end_y;
    logic        in_x, in_y, win, line_end;
    logic [7:0]  r_left, g_left, b_left;
    logic [23:0] pix_rgb;
    logic        vde_d2, hsync_d2, vsync_d2, win_d2;

    // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
    always_comb begin
        mode_shift = scale_shift(i_scale_mode);
        sub_last   = {shift[1], |shift};
        end_x      = {4'd0, off_x} + (16'(SRC_H) << shift);
        end_y      = {4'd0, off_y} + (16'(SRC_V) << shift);
        in_x       = (cx >= off_x) && ({4'd0, cx} < end_x);
        in_y       = (ly >= off_y) && ({4'd0, ly} < end_y);
        line_end   = vde_q && !i_vde;
        win        = (state == ACTIVE) && !i_vsync && i_vde && in_x && in_y;
    end

    // Stage 1: counters, window decision and read address.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= WAIT_FRAME;
            shift      <= 2'd0;
            border_rgb <= 24'h0;
            off_x      <= 12'd0;
            off_y      <= 12'd0;
            cx         <= 12'd0;
            ly         <= 12'd0;
            hsub       <= 2'd0;
            vsub       <= 2'd0;
            src_col    <= '0;
            row_base   <= '0;
            vde_q      <= 1'b0;
            o_rd_en    <= 1'b0;
            o_rd_addr  <= '0;
        end else begin
            vde_q <= i_vde;
            if (i_vsync) begin
                state      <= ACTIVE;
                shift      <= mode_shift;
                border_rgb <= i_border_rgb;
                off_x      <= centre_offset(16'(DST_H), 16'(SRC_H) << mode_shift);
                off_y      <= centre_offset(16'(DST_V), 16'(SRC_V) << mode_shift);
                cx         <= 12'd0;
                ly         <= 12'd0;
                hsub       <= 2'd0;
                vsub       <= 2'd0;
                src_col    <= '0;
                row_base   <= '0;
                o_rd_en    <= 1'b0;
            end else begin
                cx <= i_vde ? cx + 12'd1 : 12'd0;
                if (line_end) ly <= ly + 12'd1;

                if (i_vde && in_x) begin
                    if (hsub == sub_last) begin
                        hsub    <= 2'd0;
                        src_col <= src_col + ADDR_W'(1);
                    end else begin
                        hsub <= hsub + 2'd1;
                    end
                end else if (!i_vde) begin
                    hsub    <= 2'd0;
                    src_col <= '0;
                end

                if (line_end && in_y) begin
                    if (vsub == sub_last) begin
                        vsub     <= 2'd0;
                        row_base <= row_base + ADDR_W'(SRC_H);
                    end else begin
                        vsub <= vsub + 2'd1;
                    end
                end

                o_rd_en <= win;
                if (win) o_rd_addr <= row_base + src_col;
            end
        end
    end

    video_sync_delay #(
        .DEPTH (LATENCY - 1)
    ) u_sync_delay (
        .i_clk_pixel (i_clk_pixel),
        .i_rstn      (i_rstn),
        .i_vde       (i_vde),
        .i_hsync     (i_hsync),
        .i_vsync     (i_vsync),
        .i_win       (win),
        .o_vde       (vde_d2),
        .o_hsync     (hsync_d2),
        .o_vsync     (vsync_d2),
        .o_win       (win_d2)
    );

    always_comb begin
        r_left  = 8'(i_rd_data[PIX_W-1 -: CH_W]) << (8 - CH_W);
        g_left  = 8'(i_rd_data[2*CH_W-1 -: CH_W]) << (8 - CH_W);
        b_left  = 8'(i_rd_data[CH_W-1 -: CH_W]) << (8 - CH_W);
        pix_rgb = {expand_ch(r_left, CH_W), expand_ch(g_left, CH_W), expand_ch(b_left, CH_W)};
    end

    // Stage 3: BRAM data is valid here, aligned with the stage-2 flags.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            o_video_data  <= 24'h0;
            o_video_vde   <= 1'b0;
            o_video_hsync <= 1'b0;
            o_video_vsync <= 1'b0;
        end else begin
            o_video_vde   <= vde_d2;
            o_video_hsync <= hsync_d2;
            o_video_vsync <= vsync_d2;
            if (win_d2)      o_video_data <= pix_rgb;
            else if (vde_d2) o_video_data <= border_rgb;
            else             o_video_data <= 24'h0;
        end
    end

endmodule

// File: tb/tb_video_frame_scaler.sv
// Scoreboard bench for video_frame_scaler on a reduced-size geometry with the
// default aspect ratios; expectations come from a division-based reference map.
module tb_video_frame_scaler;

    localparam int SRC_H   = 16;
    localparam int SRC_V   = 12;
    localparam int DST_H   = 32;
    localparam int DST_V   = 24;
    localparam int CH_W    = 4;
    localparam int ADDR_W  = 8;
    localparam int H_BLANK = 8;
    localparam int LAT     = 3;

    logic              clk;
    logic              rstn;
    logic [1:0]        scale_mode;
    logic [23:0]       border_rgb;
    logic              vde, hsync, vsync;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [11:0]       rd_data;
    logic [23:0]       video_data;
    logic              video_vde, video_hsync, video_vsync;

    video_frame_scaler #(
        .SRC_H (SRC_H), .SRC_V (SRC_V), .DST_H (DST_H), .DST_V (DST_V),
        .CH_W (CH_W), .ADDR_W (ADDR_W)
    ) dut (
        .i_clk_pixel   (clk),
        .i_rstn        (rstn),
        .i_scale_mode  (scale_mode),
        .i_border_rgb  (border_rgb),
        .i_vde         (vde),
        .i_hsync       (hsync),
        .i_vsync       (vsync),
        .o_rd_en       (rd_en),
        .o_rd_addr     (rd_addr),
        .i_rd_data     (rd_data),
        .o_video_data  (video_data),
        .o_video_vde   (video_vde),
        .o_video_hsync (video_hsync),
        .o_video_vsync (video_vsync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] mem [256];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct {
        logic        vde, hs, vs;
        logic [23:0] data;
        int          x, y;
    } exp_t;
    exp_t q_out[$];

    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_active;
    int          m_s, m_ox, m_oy, m_cx, m_ly;
    logic [23:0] m_border;
    bit          m_vde_prev;
    int          max_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] expand12(input logic [11:0] p);
        return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
    endfunction

    function automatic int scale_of(input logic [1:0] mode);
        return (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 1;
    endfunction

    task automatic model_reset();
        q_out.delete();
        m_active = 0; m_s = 1; m_ox = 0; m_oy = 0;
        m_cx = 0; m_ly = 0; m_border = 24'h0; m_vde_prev = 0;
    endtask

    task automatic tick(input logic v, input logic hs, input logic vs);
        exp_t e;
        logic exp_en;
        int   exp_addr;
        vde = v; hsync = hs; vsync = vs;
        exp_en = m_active && !vs && v &&
                 m_cx >= m_ox && m_cx < m_ox + m_s*SRC_H &&
                 m_ly >= m_oy && m_ly < m_oy + m_s*SRC_V;
        exp_addr = exp_en ? ((m_ly - m_oy) / m_s) * SRC_H + (m_cx - m_ox) / m_s : 0;
        e.vde = v; e.hs = hs; e.vs = vs; e.x = m_cx; e.y = m_ly;
        e.data = exp_en ? expand12(mem[exp_addr]) : (v ? m_border : 24'h0);
        q_out.push_back(e);

        if (vs) begin
            m_active = 1;
            m_s      = scale_of(scale_mode);
            m_border = border_rgb;
            m_ox     = (m_s*SRC_H < DST_H) ? (DST_H - m_s*SRC_H) / 2 : 0;
            m_oy     = (m_s*SRC_V < DST_V) ? (DST_V - m_s*SRC_V) / 2 : 0;
            m_cx     = 0;
            m_ly     = 0;
        end else begin
            if (m_vde_prev && !v) m_ly++;
            m_cx = v ? m_cx + 1 : 0;
        end
        m_vde_prev = v;

        @(posedge clk); #1;
        check($sformatf("rd_en@%0d,%0d", e.x, e.y), rd_en, exp_en);
        if (exp_en) check($sformatf("rd_addr@%0d,%0d", e.x, e.y), rd_addr, exp_addr);
        if (rd_en && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        if (q_out.size() == LAT) begin
            exp_t o;
            o = q_out.pop_front();
            check($sformatf("vde@%0d,%0d", o.x, o.y), video_vde, o.vde);
            check($sformatf("hsync@%0d,%0d", o.x, o.y), video_hsync, o.hs);
            check($sformatf("vsync@%0d,%0d", o.x, o.y), video_vsync, o.vs);
            check($sformatf("data@%0d,%0d", o.x, o.y), video_data, o.data);
        end
    endtask

    task automatic line(input int n_pix);
        for (int x = 0; x < n_pix; x++) tick(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < H_BLANK; b++) tick(1'b0, (b >= 2 && b < 5), 1'b0);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Mode and border are rewritten halfway down the frame; they must only take effect at the next vsync.
    task automatic frame(input logic [1:0] mode, input logic [1:0] mid_mode, input logic [23:0] border);
        scale_mode = mode;
        border_rgb = border;
        vsync_pulse();
        for (int y = 0; y < DST_V; y++) begin
            if (y == DST_V/2) begin
                scale_mode = mid_mode;
                border_rgb = ~border;
            end
            line(DST_H);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},   rd_en, 1'b0);
        check({tag, "_rd_addr"}, rd_addr, '0);
        check({tag, "_data"},    video_data, 24'h0);
        check({tag, "_vde"},     video_vde, 1'b0);
        check({tag, "_hsync"},   video_hsync, 1'b0);
        check({tag, "_vsync"},   video_vsync, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 12'(a*149 + 7) ^ 12'(a << 5);
        mem[0] = 12'hF80;
        rstn = 1'b0; scale_mode = 2'd0; border_rgb = 24'h0;
        vde = 1'b0; hsync = 1'b0; vsync = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;

        // Outputs stay black and no reads occur before the first vsync.
        line(DST_H);

        frame(2'd1, 2'd1, 24'h123456);
        frame(2'd0, 2'd0, 24'h0000FF);

        max_addr = -1;
        frame(2'd2, 2'd2, 24'hA5A5A5);
        check("crop_max_addr", max_addr, (DST_V/4 - 1)*SRC_H + DST_H/4 - 1);

        frame(2'd2, 2'd1, 24'h00FF00);
        frame(2'd1, 2'd1, 24'hFF0000);

        // Reset mid-line inside the image window.
        scale_mode = 2'd1;
        border_rgb = 24'h3C3C3C;
        vsync_pulse();
        for (int y = 0; y < 3; y++) line(DST_H);
        for (int x = 0; x < 10; x++) tick(1'b1, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        vde = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
        for (int y = 0; y < 3; y++) line(DST_H);
        frame(2'd1, 2'd1, 24'h0F0F0F);

        frame(2'd3, 2'd3, 24'h808080);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
